seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display driven through a single Dec7Seg decoder. It holds a 16-bit hex value (4 nibbles) plus decimal points and steps through the digits one at a time. For each digit it presents the nibble to the decoder and enables that digit's anode. A blanking gap between digits prevents ghosting, and new values are committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seg7_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display that shares one hex-to-segment decoder. Each digit gets an
//   anode-off BLANK gap, which prevents ghosting, followed by a SHOW phase.
//   New values are staged in a shadow register and reach the display register
//   only at a frame boundary, or in IDLE. A frame therefore never mixes old
//   and new digits.
//
//   Ports:
//     Clk        in   system clock, rising edge
//     Rst        in   asynchronous reset, active-high
//     Enable     in   1 = scanning, 0 = display dark (returns to IDLE)
//     Load       in   one-cycle strobe capturing Value/DpIn into the shadow
//     Value[15:0] in  digit n = Value[4n+3:4n], digit 0 rightmost
//     DpIn[3:0]  in   decimal point per digit, 1 = lit
//     Nibble[3:0] out registered nibble for the decoder, loaded on BLANK entry
//     DpOut      out  registered decimal point of the current digit
//     An[3:0]    out  registered anode enables, active-low
//     FrameDone  out  high during the last SHOW cycle of digit 3
//
//   Build option:
//     LEADING_ZERO_BLANK_EN - when defined, digits 3..1 stay dark in SHOW if
//     their nibble and all higher nibbles are zero. Timing is unchanged.
//
//   state | meaning
//   IDLE  | anodes off, waiting for Enable
//   BLANK | anodes off for BLANK_CYCLES, nibble/dp already set for idx
//   SHOW  | anode idx on for CLK_DIV cycles
// -----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic        Load,
    input  logic [15:0] Value,
    input  logic [3:0]  DpIn,
    output logic [3:0]  Nibble,
    output logic        DpOut,
    output logic [3:0]  An,
    output logic        FrameDone
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [15:0]       shadow_val_q, shadow_val_d;
    logic [3:0]        shadow_dp_q, shadow_dp_d;
    logic [15:0]       disp_val_q, disp_val_d;
    logic [3:0]        disp_dp_q, disp_dp_d;
    logic              pending_q, pending_d;
    logic [3:0]        nibble_q, nibble_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;

    logic              frame_end;
    logic              commit_slot;
    logic              load_digit;
    logic              lz_dark;

    assign frame_end   = (state_q == ST_SHOW) && (cnt_q == '0) && (idx_q == 2'd3) && Enable;
    // IDLE commits a pending value one cycle after the Load that set it.
    assign commit_slot = frame_end || ((state_q == ST_IDLE) && pending_q);

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        case (idx_q)
            2'd3:    lz_dark = (disp_val_q[15:12] == 4'h0);
            2'd2:    lz_dark = (disp_val_q[15:8]  == 8'h0);
            2'd1:    lz_dark = (disp_val_q[15:4]  == 12'h0);
            default: lz_dark = 1'b0;
        endcase
    end
`else
    assign lz_dark = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        nibble_d     = nibble_q;
        dp_d         = dp_q;
        an_d         = an_q;
        load_digit   = 1'b0;

        if (Load) begin
            shadow_val_d = Value;
            shadow_dp_d  = DpIn;
        end

        // A Load coinciding with a commit bypasses the shadow.
        if (commit_slot) begin
            pending_d = 1'b0;
            if (Load) begin
                disp_val_d = Value;
                disp_dp_d  = DpIn;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
            end
        end else if (Load) begin
            pending_d = 1'b1;
        end

        if (!Enable) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            an_d    = 4'hF;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_BLANK;
                    idx_d      = 2'd0;
                    cnt_d      = BLANK_LOAD;
                    an_d       = 4'hF;
                    load_digit = 1'b1;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHOW;
                        cnt_d   = SHOW_LOAD;
                        an_d    = lz_dark ? 4'hF : ~(4'b0001 << idx_q);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        state_d    = ST_BLANK;
                        cnt_d      = BLANK_LOAD;
                        idx_d      = idx_q + 2'd1;
                        an_d       = 4'hF;
                        load_digit = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    an_d    = 4'hF;
                end
            endcase
        end

        // Digit data comes from the post-commit display so a new frame
        // starts with new digits from its very first BLANK cycle.
        if (load_digit) begin
            nibble_d = disp_val_d[{idx_d, 2'b00} +: 4];
            dp_d     = disp_dp_d[idx_d];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            disp_val_q   <= 16'h0000;
            disp_dp_q    <= 4'h0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'h0;
            dp_q         <= 1'b0;
            an_q         <= 4'hF;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign Nibble    = nibble_q;
    assign DpOut     = dp_q;
    assign An        = an_q;
    assign FrameDone = frame_end;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Enable;
    logic        Load;
    logic [15:0] Value;
    logic [3:0]  DpIn;
    logic [3:0]  Nibble;
    logic        DpOut;
    logic [3:0]  An;
    logic        FrameDone;

    seg7_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Enable    (Enable),
        .Load      (Load),
        .Value     (Value),
        .DpIn      (DpIn),
        .Nibble    (Nibble),
        .DpOut     (DpOut),
        .An        (An),
        .FrameDone (FrameDone)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [3:0] an;
        logic [3:0] nib;
        logic       dp;
        logic       fd;
    } ev_t;

    ev_t        exp_q[$];
    logic [3:0] exp_an = 4'hF;
    logic [3:0] an_prev = 4'hF;
    int         total = 0;
    int         bad = 0;

    // Monitor: every An change or FrameDone pulse is an output event.
    always @(negedge Clk) begin
        ev_t e;
        total++;
        if ($countones(~An) > 1) begin
            bad++;
            $display("FAIL one_anode cyc=%0d An=%b (at most one low required)", cyc, An);
        end
        if (An !== an_prev || FrameDone === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d An=%b Nibble=%h DpOut=%b FrameDone=%b",
                         cyc, An, Nibble, DpOut, FrameDone);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.an !== An || e.nib !== Nibble || e.dp !== DpOut || e.fd !== FrameDone) begin
                    bad++;
                    $display("FAIL event got cyc=%0d An=%b Nib=%h Dp=%b Fd=%b want cyc=%0d An=%b Nib=%h Dp=%b Fd=%b",
                             cyc, An, Nibble, DpOut, FrameDone, e.t, e.an, e.nib, e.dp, e.fd);
                end
            end
        end
        an_prev = An;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, expv);
        end
    endtask

    task automatic push_ev(input int t, input logic [3:0] an, input logic [3:0] nib,
                           input logic dp, input logic fd);
        ev_t e;
        if (an != exp_an || fd) begin
            e.t = t; e.an = an; e.nib = nib; e.dp = dp; e.fd = fd;
            exp_q.push_back(e);
        end
        exp_an = an;
    endtask

    function automatic logic [3:0] nib_of(input logic [15:0] v, input int k);
        return v[4*k +: 4];
    endfunction

    function automatic logic [3:0] an_of(input logic [15:0] v, input int k);
        logic [3:0] one;
        one = 4'b0001;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (v >> (4*k)) == 16'h0) return 4'hF;
`endif
        return ~(one << k);
    endfunction

    // Digit k of a frame whose first BLANK cycle is b.
    task automatic push_digit(input int b, input int k, input logic [15:0] v, input logic [3:0] dp);
        push_ev(b + 6*k,     4'hF,       nib_of(v, k), dp[k], 1'b0);
        push_ev(b + 6*k + 2, an_of(v, k), nib_of(v, k), dp[k], 1'b0);
    endtask

    task automatic push_frame(input int b, input logic [15:0] v, input logic [3:0] dp);
        for (int k = 0; k < 4; k++) push_digit(b, k, v, dp);
        push_ev(b + 23, an_of(v, 3), nib_of(v, 3), dp[3], 1'b1);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        Load = 1'b1; Value = v; DpIn = dp;
        step();
        Load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expired before end of test", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, c, f;
        Rst = 1'b1; Enable = 1'b0; Load = 1'b0; Value = 16'h0; DpIn = 4'h0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("rst_an", {12'h0, An}, 16'h000F);
        check("rst_nibble", {12'h0, Nibble}, 16'h0000);
        check("rst_dp", {15'h0, DpOut}, 16'h0000);
        check("rst_fd", {15'h0, FrameDone}, 16'h0000);

        // Scan with nothing loaded: two frames of zeros.
        step();
        b = cyc + 1;
        Enable = 1'b1;
        push_frame(b, 16'h0000, 4'h0);
        push_frame(b + 24, 16'h0000, 4'h0);
        push_ev(b + 48, 4'hF, 4'h0, 1'b0, 1'b0);
        wait_until(b + 48);
        Enable = 1'b0;

        // Load in IDLE, then enable.
        wait_until(b + 50);
        c = cyc;
        do_load(16'h1A2F, 4'b0100);
        wait_until(c + 3);
        Enable = 1'b1;
        b = c + 4;
        push_frame(b, 16'h1A2F, 4'b0100);

        // Loads while scanning take effect at the next frame.
        wait_until(b + 5);
        do_load(16'h1234, 4'b0001);
        push_frame(b + 24, 16'h1234, 4'b0001);
        wait_until(b + 34);
        do_load(16'hABCD, 4'b1000);
        push_frame(b + 48, 16'hABCD, 4'b1000);
        wait_until(b + 50);
        do_load(16'h5555, 4'b1111);
        wait_until(b + 52);
        do_load(16'h7777, 4'b0010);
        push_frame(b + 72, 16'h7777, 4'b0010);
        // Load on the FrameDone cycle is committed directly.
        wait_until(b + 95);
        do_load(16'h9876, 4'b0000);
        push_frame(b + 96, 16'h9876, 4'h0);
        push_frame(b + 120, 16'h9876, 4'h0);

        // Drop Enable mid-SHOW of digit 2.
        f = b + 144;
        push_digit(f, 0, 16'h9876, 4'h0);
        push_digit(f, 1, 16'h9876, 4'h0);
        push_digit(f, 2, 16'h9876, 4'h0);
        wait_until(f + 15);
        Enable = 1'b0;
        push_ev(f + 16, 4'hF, 4'h8, 1'b0, 1'b0);
        wait_until(f + 40);
        Enable = 1'b1;
        b = f + 41;
        push_frame(b, 16'h9876, 4'h0);

        // Asynchronous reset mid-SHOW of digit 0.
        push_digit(b + 24, 0, 16'h9876, 4'h0);
        wait_until(b + 27);
        push_ev(b + 27, 4'hF, 4'h0, 1'b0, 1'b0);
        #2;
        Rst = 1'b1;
        Enable = 1'b0;
        #1;
        check("async_rst_an", {12'h0, An}, 16'h000F);
        check("async_rst_nibble", {12'h0, Nibble}, 16'h0000);
        check("async_rst_dp", {15'h0, DpOut}, 16'h0000);
        step();
        step();
        Rst = 1'b0;
        step();
        Enable = 1'b1;
        b = cyc + 1;
        push_frame(b, 16'h0000, 4'h0);
        push_ev(b + 24, 4'hF, 4'h0, 1'b0, 1'b0);
        wait_until(b + 24);
        Enable = 1'b0;

        // Leading zeros.
        step();
        do_load(16'h0050, 4'h0);
        step();
        step();
        Enable = 1'b1;
        b = cyc + 1;
        push_frame(b, 16'h0050, 4'h0);
        push_ev(b + 24, 4'hF, 4'h0, 1'b0, 1'b0);
        wait_until(b + 24);
        Enable = 1'b0;

        repeat (6) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
